// File: rtl/time_entry_pkg.sv
// Shared types and digit limits for the HH:MM[:SS] keypad time-entry block.
// The per-position limits are derived from the largest legal hour and minute/second values.
package time_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [7:0] HOURS_MAX   = 8'd23;
    localparam logic [7:0] MIN_SEC_MAX = 8'd59;

    localparam logic [3:0] LIM_H1           = 4'(HOURS_MAX / 8'd10);
    localparam logic [3:0] LIM_H0           = 4'd9;
    localparam logic [3:0] LIM_H0_AT_H1_MAX = 4'(HOURS_MAX % 8'd10);
    localparam logic [3:0] LIM_M1           = 4'(MIN_SEC_MAX / 8'd10);
    localparam logic [3:0] LIM_M0           = 4'd9;
    localparam logic [3:0] LIM_S1           = 4'(MIN_SEC_MAX / 8'd10);
    localparam logic [3:0] LIM_S0           = 4'd9;

    // The hours-units limit depends on the hours-tens digit already in the buffer.
    function automatic logic digit_in_range(input logic [2:0] p,
                                            input logic [3:0] d,
                                            input logic [3:0] h1);
        logic [3:0] lim;
        case (p)
            3'd0:    lim = LIM_H1;
            3'd1:    lim = (h1 == LIM_H1) ? LIM_H0_AT_H1_MAX : LIM_H0;
            3'd2:    lim = LIM_M1;
            3'd3:    lim = LIM_M0;
            3'd4:    lim = LIM_S1;
            3'd5:    lim = LIM_S0;
            default: lim = 4'd0;
        endcase
        return (d <= lim);
    endfunction

endpackage

// File: rtl/time_entry_bcd_pair.sv
// Combinational conversion of a two-digit BCD pair into an 8-bit binary value.
// tens*10 is formed as tens*8 + tens*2 so no multiplier is needed.
module bcd_pair_to_bin (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] bin
);

    logic [7:0] tens_w;
    logic [7:0] ones_w;

    assign tens_w = {4'd0, tens};
    assign ones_w = {4'd0, ones};
    assign bin    = (tens_w << 3) + (tens_w << 1) + ones_w;

endmodule

// File: rtl/time_entry.sv
// Keypad time entry: collects validated BCD digits into HH MM [SS], then offers
// the binary time on a valid/ready handshake to the time or alarm counter.
module time_entry
    import time_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    output logic        digit_ready,
    input  logic        clear,
    output logic [7:0]  hrs,
    output logic [7:0]  min,
    output logic [7:0]  sec,
    output logic        load_valid,
    input  logic        load_ready,
    output logic [23:0] entry_digits,
    output logic [2:0]  pos,
    output logic        entry_active,
    output logic        error
);

    localparam logic [2:0] LAST_POS = 3'(NUM_DIGITS - 1);

    state_t      state_q, state_d;
    logic [2:0]  pos_q, pos_d;
    logic [23:0] buf_q, buf_d;
    logic [7:0]  hrs_q, hrs_d;
    logic [7:0]  min_q, min_d;
    logic [7:0]  sec_q, sec_d;
    logic        load_valid_q, load_valid_d;
    logic        error_q, error_d;

    logic [4:0]  slot_shift;
    logic [23:0] buf_written;
    logic        digit_ok;
    logic [7:0]  hrs_bin, min_bin, sec_bin;

    // Slot 0 (H1) sits in the top nibble, so the shift shrinks as pos grows.
    assign slot_shift  = 5'd20 - {pos_q, 2'b00};
    assign buf_written = (buf_q & ~(24'hF << slot_shift)) | ({20'd0, digit} << slot_shift);
    assign digit_ok    = digit_in_range(pos_q, digit, buf_q[23:20]);

    // Conversion runs on the buffer including the digit being accepted, so the
    // binary fields can be registered on the same edge as the last digit.
    bcd_pair_to_bin u_hrs (
        .tens (buf_written[23:20]),
        .ones (buf_written[19:16]),
        .bin  (hrs_bin)
    );

    bcd_pair_to_bin u_min (
        .tens (buf_written[15:12]),
        .ones (buf_written[11:8]),
        .bin  (min_bin)
    );

    bcd_pair_to_bin u_sec (
        .tens (buf_written[7:4]),
        .ones (buf_written[3:0]),
        .bin  (sec_bin)
    );

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        buf_d        = buf_q;
        hrs_d        = hrs_q;
        min_d        = min_q;
        sec_d        = sec_q;
        load_valid_d = load_valid_q;
        error_d      = 1'b0;

        if (clear) begin
            state_d      = IDLE;
            pos_d        = 3'd0;
            buf_d        = 24'd0;
            load_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ENTRY: begin
                    if (digit_valid) begin
                        if (digit_ok) begin
                            buf_d = buf_written;
                            if (pos_q == LAST_POS) begin
                                state_d      = LOAD;
                                load_valid_d = 1'b1;
                                hrs_d        = hrs_bin;
                                min_d        = min_bin;
                                sec_d        = (NUM_DIGITS == 6) ? sec_bin : 8'd0;
                            end else begin
                                state_d = ENTRY;
                                pos_d   = pos_q + 3'd1;
                            end
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // Binary fields keep the transferred value after the handshake.
                    if (load_ready) begin
                        state_d      = IDLE;
                        pos_d        = 3'd0;
                        buf_d        = 24'd0;
                        load_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_q        <= 3'd0;
            buf_q        <= 24'd0;
            hrs_q        <= 8'd0;
            min_q        <= 8'd0;
            sec_q        <= 8'd0;
            load_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            buf_q        <= buf_d;
            hrs_q        <= hrs_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            load_valid_q <= load_valid_d;
            error_q      <= error_d;
        end
    end

    assign digit_ready  = (state_q != LOAD);
    assign entry_active = (state_q == ENTRY);
    assign hrs          = hrs_q;
    assign min          = min_q;
    assign sec          = sec_q;
    assign load_valid   = load_valid_q;
    assign entry_digits = buf_q;
    assign pos          = pos_q;
    assign error        = error_q;

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: directed entry scenarios plus random digit/clear/ready
// traffic, all compared each cycle against a digit-list reference model.
module tb_time_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        clear;
    logic        load_ready;

    logic        dr6, lv6, act6, err6;
    logic [7:0]  hrs6, min6, sec6;
    logic [23:0] ed6;
    logic [2:0]  pos6;
    logic        dr4, lv4, act4, err4;
    logic [7:0]  hrs4, min4, sec4;
    logic [23:0] ed4;
    logic [2:0]  pos4;

    always #5 clk = ~clk;

    time_entry #(.NUM_DIGITS(6)) dut6 (
        .clk(clk), .reset(reset), .digit(digit), .digit_valid(digit_valid),
        .digit_ready(dr6), .clear(clear), .hrs(hrs6), .min(min6), .sec(sec6),
        .load_valid(lv6), .load_ready(load_ready), .entry_digits(ed6),
        .pos(pos6), .entry_active(act6), .error(err6)
    );

    time_entry #(.NUM_DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .digit(digit), .digit_valid(digit_valid),
        .digit_ready(dr4), .clear(clear), .hrs(hrs4), .min(min4), .sec(sec4),
        .load_valid(lv4), .load_ready(load_ready), .entry_digits(ed4),
        .pos(pos4), .entry_active(act4), .error(err4)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int sel    = 6;

    // Reference model: the list of accepted digits plus the handed-off time.
    int q[$];
    bit m_load;
    bit m_err;
    int m_h, m_m, m_s;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit legal(input int d);
        int p;
        p = q.size();
        if (d > 9) return 1'b0;
        case (p)
            0:       return d <= 2;
            1:       return (q[0] * 10 + d) <= 23;
            2, 4:    return d <= 5;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_load = 1'b0;
        m_err  = 1'b0;
        m_h    = 0;
        m_m    = 0;
        m_s    = 0;
    endtask

    task automatic model_step(input int d, input bit dv, input bit clr, input bit lr);
        m_err = 1'b0;
        if (clr) begin
            q.delete();
            m_load = 1'b0;
        end else if (m_load) begin
            if (lr) begin
                q.delete();
                m_load = 1'b0;
            end
        end else if (dv) begin
            if (legal(d)) begin
                q.push_back(d);
                if (q.size() == sel) begin
                    m_load = 1'b1;
                    m_h = q[0] * 10 + q[1];
                    m_m = q[2] * 10 + q[3];
                    m_s = (sel == 6) ? q[4] * 10 + q[5] : 0;
                end
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int exp_ed;
        int exp_pos;
        exp_ed = 0;
        foreach (q[i]) exp_ed = exp_ed | (q[i] << (20 - 4 * i));
        exp_pos = m_load ? sel - 1 : q.size();
        if (sel == 6) begin
            check({tag, ".hrs"},  int'(hrs6), m_h);
            check({tag, ".min"},  int'(min6), m_m);
            check({tag, ".sec"},  int'(sec6), m_s);
            check({tag, ".lv"},   int'(lv6),  int'(m_load));
            check({tag, ".rdy"},  int'(dr6),  int'(!m_load));
            check({tag, ".ed"},   int'(ed6),  exp_ed);
            check({tag, ".pos"},  int'(pos6), exp_pos);
            check({tag, ".act"},  int'(act6), int'(!m_load && q.size() > 0));
            check({tag, ".err"},  int'(err6), int'(m_err));
        end else begin
            check({tag, ".hrs"},  int'(hrs4), m_h);
            check({tag, ".min"},  int'(min4), m_m);
            check({tag, ".sec"},  int'(sec4), m_s);
            check({tag, ".lv"},   int'(lv4),  int'(m_load));
            check({tag, ".rdy"},  int'(dr4),  int'(!m_load));
            check({tag, ".ed"},   int'(ed4),  exp_ed);
            check({tag, ".pos"},  int'(pos4), exp_pos);
            check({tag, ".act"},  int'(act4), int'(!m_load && q.size() > 0));
            check({tag, ".err"},  int'(err4), int'(m_err));
        end
    endtask

    // Called at posedge+1: drive inputs, predict, clock, then compare.
    task automatic cyc(input int d, input bit dv, input bit clr, input bit lr, input string tag);
        digit       = 4'(d);
        digit_valid = dv;
        clear       = clr;
        load_ready  = lr;
        model_step(d, dv, clr, lr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        digit       = 4'd0;
        digit_valid = 1'b0;
        clear       = 1'b0;
        load_ready  = 1'b0;
        reset       = 1'b1;
        model_reset();
        #12;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all({tag, ".rel"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq_a[6];
        int seq_b[6];
        int seq_c[4];
        int d;
        bit dv, clr, lr;

        sel = 6;
        do_reset("rst");

        // 1,2,3,4,5,6 with the consumer already ready
        seq_a = '{1, 2, 3, 4, 5, 6};
        foreach (seq_a[i]) cyc(seq_a[i], 1'b1, 1'b0, 1'b1, "s37");
        check("s37.hrs_val", int'(hrs6), 12);
        check("s37.min_val", int'(min6), 34);
        check("s37.sec_val", int'(sec6), 56);
        check("s37.lv_high", int'(lv6), 1);
        cyc(0, 1'b0, 1'b0, 1'b1, "s37b");
        check("s37.lv_pulse", int'(lv6), 0);
        check("s37.pos_zero", int'(pos6), 0);

        // rejected hours units after a 2
        cyc(2, 1'b1, 1'b0, 1'b0, "s38");
        cyc(4, 1'b1, 1'b0, 1'b0, "s38");
        check("s38.err", int'(err6), 1);
        check("s38.pos", int'(pos6), 1);
        cyc(3, 1'b1, 1'b0, 1'b0, "s38");
        check("s38.err_once", int'(err6), 0);
        repeat (4) cyc(0, 1'b1, 1'b0, 1'b0, "s38");
        check("s38.hrs_val", int'(hrs6), 23);
        check("s38.min_val", int'(min6), 0);
        cyc(0, 1'b0, 1'b0, 1'b1, "s38b");

        // consumer stalls while strobes keep arriving
        seq_b = '{2, 3, 5, 9, 5, 9};
        foreach (seq_b[i]) cyc(seq_b[i], 1'b1, 1'b0, 1'b0, "s39");
        repeat (5) begin
            cyc($urandom_range(0, 15), 1'b1, 1'b0, 1'b0, "s39h");
            check("s39.hrs_val", int'(hrs6), 23);
            check("s39.sec_val", int'(sec6), 59);
            check("s39.rdy", int'(dr6), 0);
            check("s39.no_err", int'(err6), 0);
        end
        cyc(0, 1'b0, 1'b0, 1'b1, "s39b");

        // clear mid-entry, colliding with a digit strobe
        cyc(1, 1'b1, 1'b0, 1'b0, "s40");
        cyc(2, 1'b1, 1'b0, 1'b0, "s40");
        cyc(3, 1'b1, 1'b0, 1'b0, "s40");
        cyc(4, 1'b1, 1'b1, 1'b0, "s40c");
        check("s40.pos", int'(pos6), 0);
        check("s40.ed", int'(ed6), 0);

        // non-BCD digit at position 0
        cyc(10, 1'b1, 1'b0, 1'b0, "s41");
        check("s41.err", int'(err6), 1);
        check("s41.idle", int'(act6), 0);
        cyc(0, 1'b0, 1'b0, 1'b0, "s41b");

        // asynchronous reset while holding a time in LOAD
        foreach (seq_a[i]) cyc(seq_a[i], 1'b1, 1'b0, 1'b0, "s42");
        check("s42.lv_before", int'(lv6), 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("s42.async");
        check("s42.lv_async", int'(lv6), 0);
        #1;
        reset = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b0, "s42b");

        // clear together with load_ready aborts the transfer
        foreach (seq_a[i]) cyc(seq_a[i], 1'b1, 1'b0, 1'b0, "s29");
        cyc(0, 1'b0, 1'b1, 1'b1, "s29c");

        repeat (1500) begin
            d   = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            dv  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 99) < 3);
            lr  = ($urandom_range(0, 9) < 4);
            cyc(d, dv, clr, lr, "rnd6");
        end

        sel = 4;
        do_reset("rst4");
        seq_c = '{0, 7, 4, 5};
        foreach (seq_c[i]) cyc(seq_c[i], 1'b1, 1'b0, 1'b0, "s41n4");
        check("s41n4.hrs_val", int'(hrs4), 7);
        check("s41n4.min_val", int'(min4), 45);
        check("s41n4.sec_val", int'(sec4), 0);
        check("s41n4.lv", int'(lv4), 1);
        cyc(0, 1'b0, 1'b0, 1'b1, "s41n4b");

        repeat (800) begin
            d   = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            dv  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 99) < 3);
            lr  = ($urandom_range(0, 9) < 4);
            cyc(d, dv, clr, lr, "rnd4");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of digits per entry: 6 for HH MM SS, 4 for HH MM; other values are illegal.
REQ-002 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port digit, input, 4, BCD digit value presented with digit_valid.
REQ-005 SHALL have port digit_valid, input, 1, digit strobe; sampled only when digit_ready=1.
REQ-006 SHALL have port digit_ready, output, 1, block can accept a digit.
REQ-007 SHALL have port clear, input, 1, abort the entry and empty the buffer.
REQ-008 SHALL have port hrs, output, 8, binary hours 0..23.
REQ-009 SHALL have port min, output, 8, binary minutes 0..59.
REQ-010 SHALL have port sec, output, 8, binary seconds 0..59; 0 when NUM_DIGITS=4.
REQ-011 SHALL have port load_valid, output, 1, hrs/min/sec hold a complete validated time.
REQ-012 SHALL have port load_ready, input, 1, consumer (time/alarm counter) takes the value.
REQ-013 SHALL have port entry_digits, output, 24, BCD buffer {H1,H0,M1,M0,S1,S0}, 4 bits each, for the 7-segment display; unentered digits are 0.
REQ-014 SHALL have port pos, output, 3, index of the next digit, 0..NUM_DIGITS-1.
REQ-015 SHALL have port entry_active, output, 1, at least one digit accepted, entry not yet complete.
REQ-016 SHALL have port error, output, 1, one-cycle pulse on a rejected digit.

Function
REQ-017 SHALL implement FSM states IDLE, ENTRY and LOAD; digit_ready=1 in IDLE and ENTRY, 0 in LOAD.
REQ-018 SHALL accept a digit when digit_valid=1, digit_ready=1 and the digit passes the limit for position pos.
REQ-019 SHALL apply these limits: H1<=2; H0<=9 when H1<2, H0<=3 when H1=2; M1<=5; M0<=9; S1<=5; S0<=9; any digit >9 is invalid at every position.
REQ-020 SHALL, on an accepted digit, store it at entry_digits[pos] and increment pos on the next edge.
REQ-021 SHALL, on a rejected digit, leave buffer and pos unchanged and assert error for exactly the next cycle.
REQ-022 SHALL go IDLE->ENTRY on the first accepted digit.
REQ-023 SHALL go ENTRY->LOAD on the edge that accepts digit NUM_DIGITS-1; hrs/min/sec and load_valid are registered on that same edge (latency 1 cycle after the last strobe).
REQ-024 SHALL compute each binary field as tens*10+ones in 8 bits, with no overflow for legal inputs.
REQ-025 SHALL, in LOAD, hold load_valid=1 and keep hrs/min/sec stable until load_ready=1 is sampled.
REQ-026 SHALL then go LOAD->IDLE, clear load_valid, pos and entry_digits, and keep hrs/min/sec at their last value.
REQ-027 SHALL ignore digit_valid in LOAD, with no error pulse.
REQ-028 SHALL treat clear=1 in any state as a return to IDLE with pos=0, entry_digits=0 and load_valid=0 on the next edge.
REQ-029 SHALL give clear priority over a simultaneous digit_valid; clear together with load_ready in LOAD aborts the transfer, and no transfer is counted.
REQ-030 SHALL complete the handshake in one cycle if load_ready is already 1 when load_valid rises, giving a one-cycle load_valid pulse.
REQ-031 SHALL compute entry_active as state==ENTRY.

Reset
REQ-032 SHALL, on reset, go to IDLE asynchronously with pos=0, entry_digits=0, hrs=min=sec=0, load_valid=0 and error=0; digit_ready=1 after release.
REQ-033 SHALL handle reset asserted mid-ENTRY or mid-LOAD by dropping load_valid immediately, without waiting for a clock edge.

Structure
REQ-034 SHALL put in package time_entry_pkg: the state enum, the per-position digit-limit constants (2,9,5,9,5,9), and HOURS_MAX=23 and MIN_SEC_MAX=59.
REQ-035 SHALL contain one sub-module, bcd_pair_to_bin (two BCD digits in, 8-bit binary out, combinational), instanced for hours, minutes and seconds.
REQ-036 SHALL keep the FSM, buffer, position counter and output registers in time_entry.

Verification
REQ-037 SHALL cover: digits 1,2,3,4,5,6 with load_ready=1 -> one-cycle load_valid pulse, hrs=12 min=34 sec=56, then IDLE with pos=0.
REQ-038 SHALL cover: digits 2,4 -> error pulse, pos stays 1; then 3,0,0,0,0 -> hrs=23 min=0 sec=0.
REQ-039 SHALL cover: digits 2,3,5,9,5,9 with load_ready=0 for 5 cycles -> load_valid held, 23/59/59 stable, digit_ready=0, interleaved digit strobes ignored with no error.
REQ-040 SHALL cover: clear after 3 digits, including clear and digit_valid in the same cycle -> IDLE, pos=0, entry_digits=0, digit not stored.
REQ-041 SHALL cover: digit=4'hA at pos 0 -> error pulse, state IDLE; NUM_DIGITS=4 with digits 0,7,4,5 -> hrs=7 min=45 sec=0.
REQ-042 SHALL cover: reset asserted between clock edges while in LOAD -> load_valid=0 and all outputs 0 before the next edge.
